// File: rtl/vgpr_collect_pkg.sv
// Shared definitions for the VGPR operand collector: FSM encoding and default widths.
// Optional forwarding of snooped writes is enabled by defining VGPR_COLLECT_BYPASS_EN.
package vgpr_collect_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;
   localparam int TAG_W_DEF  = 6;
   localparam int NUM_SRC    = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_VALID = 2'd3
   } state_e;

endpackage

// File: rtl/vgpr_collect_slot.sv
// One source operand lane: enable/address latch, RF read address, optional write bypass, capture.
// Forwarding logic exists only when VGPR_COLLECT_BYPASS_EN is defined.
module vgpr_collect_slot
   import vgpr_collect_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              read_phase,
   input  logic              wait_phase,
   input  logic              wr_active,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] data
);

   logic              en;
   logic [DATA_W-1:0] capture_val;

`ifdef VGPR_COLLECT_BYPASS_EN
   logic              wr_hit;
   logic              pend_v;
   logic [DATA_W-1:0] pend_d;

   // rd_addr doubles as the latched source address while the lane is enabled.
   assign wr_hit = en && wr_active && (wr_addr == rd_addr);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      capture_val = rd_data;
      if (!en)
         capture_val = '0;
      else if (wr_hit)
         capture_val = wr_data;
      else if (pend_v)
         capture_val = pend_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_v <= 1'b0;
         pend_d <= '0;
      end else if (load) begin
         pend_v <= 1'b0;
      end else if (read_phase && wr_hit) begin
         pend_v <= 1'b1;
         pend_d <= wr_data;
      end
   end
`else
   logic unused_snoop;
   assign unused_snoop = ^{wr_active, wr_addr, wr_data, read_phase};
   assign capture_val  = en ? rd_data : '0;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en      <= 1'b0;
         rd_addr <= '0;
         data    <= '0;
      end else begin
         if (load) begin
            en      <= load_en;
            rd_addr <= load_en ? load_addr : '0;
         end
         if (wait_phase)
            data <= capture_val;
      end
   end

endmodule

// File: rtl/vgpr_operand_collector.sv
// Collects up to three VGPR source operands per request and presents them with the tag.
// Define VGPR_COLLECT_BYPASS_EN to forward snooped writes that land during READ/WAIT.
module vgpr_operand_collector
   import vgpr_collect_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W  = TAG_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic [2:0]        req_src_en,
   input  logic [ADDR_W-1:0] req_src0_addr,
   input  logic [ADDR_W-1:0] req_src1_addr,
   input  logic [ADDR_W-1:0] req_src2_addr,
   output logic [ADDR_W-1:0] rf_rd0_addr,
   output logic [ADDR_W-1:0] rf_rd1_addr,
   output logic [ADDR_W-1:0] rf_rd2_addr,
   input  logic [DATA_W-1:0] rf_rd0_data,
   input  logic [DATA_W-1:0] rf_rd1_data,
   input  logic [DATA_W-1:0] rf_rd2_data,
   input  logic [ADDR_W-1:0] rf_wr0_addr,
   input  logic [3:0]        rf_wr0_en,
   input  logic [DATA_W-1:0] rf_wr0_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TAG_W-1:0]  out_tag,
   output logic [DATA_W-1:0] out_src0_data,
   output logic [DATA_W-1:0] out_src1_data,
   output logic [DATA_W-1:0] out_src2_data
);

   state_e state, state_next;
   logic   accept;
   logic   wr_active;
   logic [TAG_W-1:0] tag_q;

   logic [NUM_SRC-1:0][ADDR_W-1:0] src_addr, rd_addr;
   logic [NUM_SRC-1:0][DATA_W-1:0] rd_data, slot_data;

   assign req_ready = (state == ST_IDLE) || ((state == ST_VALID) && out_ready);
   assign accept    = req_valid && req_ready;
   assign out_valid = (state == ST_VALID);
   assign wr_active = |rf_wr0_en;

   assign src_addr = {req_src2_addr, req_src1_addr, req_src0_addr};
   assign rd_data  = {rf_rd2_data, rf_rd1_data, rf_rd0_data};
   assign {rf_rd2_addr, rf_rd1_addr, rf_rd0_addr}       = rd_addr;
   assign {out_src2_data, out_src1_data, out_src0_data} = slot_data;

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (accept) state_next = ST_READ;
         ST_READ:  state_next = ST_WAIT;
         ST_WAIT:  state_next = ST_VALID;
         ST_VALID: if (out_ready) state_next = req_valid ? ST_READ : ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_q   <= '0;
         out_tag <= '0;
      end else begin
         if (accept)
            tag_q <= req_tag;
         if (state == ST_WAIT)
            out_tag <= tag_q;
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
      vgpr_collect_slot #(
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W)
      ) u_slot (
         .clk        (clk),
         .rst        (rst),
         .load       (accept),
         .load_en    (req_src_en[i]),
         .load_addr  (src_addr[i]),
         .read_phase (state == ST_READ),
         .wait_phase (state == ST_WAIT),
         .wr_active  (wr_active),
         .wr_addr    (rf_wr0_addr),
         .wr_data    (rf_wr0_data),
         .rd_data    (rd_data[i]),
         .rd_addr    (rd_addr[i]),
         .data       (slot_data[i])
      );
   end

endmodule

// File: tb/tb_vgpr_operand_collector.sv
// Self-checking bench for vgpr_operand_collector: vector table, scoreboard queue, corner sequences.
// Expected bypass results follow VGPR_COLLECT_BYPASS_EN when it is defined for the build.
module tb_vgpr_operand_collector;
   import vgpr_collect_pkg::*;

`ifdef VGPR_COLLECT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, out_valid, out_ready;
   logic [5:0]  req_tag, out_tag;
   logic [2:0]  req_src_en;
   logic [9:0]  req_src0_addr, req_src1_addr, req_src2_addr;
   logic [9:0]  rf_rd0_addr, rf_rd1_addr, rf_rd2_addr, rf_wr0_addr;
   logic [31:0] rf_rd0_data, rf_rd1_data, rf_rd2_data, rf_wr0_data;
   logic [3:0]  rf_wr0_en;
   logic [31:0] out_src0_data, out_src1_data, out_src2_data;

   vgpr_operand_collector dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_src_en(req_src_en),
      .req_src0_addr(req_src0_addr), .req_src1_addr(req_src1_addr), .req_src2_addr(req_src2_addr),
      .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr), .rf_rd2_addr(rf_rd2_addr),
      .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
      .rf_wr0_addr(rf_wr0_addr), .rf_wr0_en(rf_wr0_en), .rf_wr0_data(rf_wr0_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .out_src0_data(out_src0_data), .out_src1_data(out_src1_data), .out_src2_data(out_src2_data)
   );

   always #5 clk = ~clk;

   // Register file model: synchronous read, data valid the cycle after the address.
   logic [31:0] mem [1024];
   always @(posedge clk) begin
      rf_rd0_data <= mem[rf_rd0_addr];
      rf_rd1_data <= mem[rf_rd1_addr];
      rf_rd2_data <= mem[rf_rd2_addr];
      if (|rf_wr0_en)
         mem[rf_wr0_addr] <= rf_wr0_data;
   end

   typedef struct packed {
      logic [5:0]        tag;
      logic [2:0]        en;
      logic [2:0][9:0]   a;
      logic [2:0][31:0]  d;
   } vec_t;

   typedef struct packed {
      logic [5:0]       tag;
      logic [2:0][31:0] d;
   } exp_t;

   exp_t sb[$];
   int   n_pass   = 0;
   int   n_checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_req(input logic [5:0] tag, input logic [2:0] en,
                            input logic [2:0][9:0] a, input logic [2:0][31:0] d, input bit push);
      exp_t e;
      req_valid     = 1'b1;
      req_tag       = tag;
      req_src_en    = en;
      req_src0_addr = a[0];
      req_src1_addr = a[1];
      req_src2_addr = a[2];
      e.tag = tag;
      e.d   = d;
      if (push)
         sb.push_back(e);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 12) begin
         step();
         lat++;
      end
   endtask

   task automatic pop_compare(input string name);
      exp_t e;
      check($sformatf("%s_out_valid", name), 32'(out_valid), 32'd1);
      check($sformatf("%s_have_exp", name), 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check($sformatf("%s_tag", name), 32'(out_tag), 32'(e.tag));
         check($sformatf("%s_src0", name), out_src0_data, e.d[0]);
         check($sformatf("%s_src1", name), out_src1_data, e.d[1]);
         check($sformatf("%s_src2", name), out_src2_data, e.d[2]);
      end
   endtask

   task automatic handshake(input string name);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check($sformatf("%s_valid_dropped", name), 32'(out_valid), 32'd0);
   endtask

   task automatic write_port(input logic [9:0] addr, input logic [31:0] data);
      rf_wr0_en   = 4'b0001;
      rf_wr0_addr = addr;
      rf_wr0_data = data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      int   lat;
      int   seen;
      logic [2:0][9:0] exp_ra;

      vecs[0] = '{tag: 6'd5,    en: 3'b111, a: {10'd30, 10'd20, 10'd10}, d: {32'hC, 32'hB, 32'hA}};
      vecs[1] = '{tag: 6'h2A,   en: 3'b010, a: {10'd30, 10'd7,  10'd10}, d: {32'h0, 32'h1234, 32'h0}};
      vecs[2] = '{tag: 6'h3F,   en: 3'b101, a: {10'd10, 10'd7,  10'd30}, d: {32'hA, 32'h0, 32'hC}};
      vecs[3] = '{tag: 6'd0,    en: 3'b000, a: {10'd3,  10'd2,  10'd1},  d: {32'h0, 32'h0, 32'h0}};

      rst = 1'b1;
      req_valid = 1'b0; req_tag = '0; req_src_en = '0;
      req_src0_addr = '0; req_src1_addr = '0; req_src2_addr = '0;
      out_ready = 1'b0; rf_wr0_en = '0; rf_wr0_addr = '0; rf_wr0_data = '0;
      #1 rst = 1'b0;

      // Preload the RF through its write port while the collector is held in reset.
      @(negedge clk);
      write_port(10'd0,  32'hBAD0);  step();
      write_port(10'd10, 32'hA);     step();
      write_port(10'd20, 32'hB);     step();
      write_port(10'd30, 32'hC);     step();
      write_port(10'd7,  32'h1234);  step();
      rf_wr0_en = '0;
      step();

      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_tag",   32'(out_tag),   32'd0);
      check("rst_src0",      out_src0_data,  32'd0);
      check("rst_rd1_addr",  32'(rf_rd1_addr), 32'd0);
      rst = 1'b1;
      step();
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      for (int v = 0; v < 4; v++) begin
         drive_req(vecs[v].tag, vecs[v].en, vecs[v].a, vecs[v].d, 1'b1);
         #1 check($sformatf("v%0d_req_ready", v), 32'(req_ready), 32'd1);
         step();
         req_valid = 1'b0;
         for (int i = 0; i < 3; i++)
            exp_ra[i] = vecs[v].en[i] ? vecs[v].a[i] : 10'd0;
         check($sformatf("v%0d_rd0_addr", v), 32'(rf_rd0_addr), 32'(exp_ra[0]));
         check($sformatf("v%0d_rd1_addr", v), 32'(rf_rd1_addr), 32'(exp_ra[1]));
         check($sformatf("v%0d_rd2_addr", v), 32'(rf_rd2_addr), 32'(exp_ra[2]));
         wait_valid(lat);
         check($sformatf("v%0d_latency", v), 32'(lat + 1), 32'd3);
         pop_compare($sformatf("v%0d", v));
         handshake($sformatf("v%0d", v));
      end

      // Backpressure: held output, blocked request, release and back-to-back accept.
      drive_req(6'd1, 3'b111, {10'd30, 10'd20, 10'd10}, {32'hC, 32'hB, 32'hA}, 1'b1);
      step();
      req_valid = 1'b0;
      wait_valid(lat);
      pop_compare("bp_first");
      drive_req(6'd2, 3'b111, {10'd20, 10'd10, 10'd30}, {32'hB, 32'hA, 32'hC}, 1'b1);
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("bp_c%0d_req_ready", c), 32'(req_ready), 32'd0);
         check($sformatf("bp_c%0d_tag", c), 32'(out_tag), 32'd1);
         check($sformatf("bp_c%0d_src1", c), out_src1_data, 32'hB);
         step();
      end
      out_ready = 1'b1;
      #1 check("bp_release_req_ready", 32'(req_ready), 32'd1);
      step();
      out_ready = 1'b0;
      req_valid = 1'b0;
      check("bp_valid_dropped", 32'(out_valid), 32'd0);
      wait_valid(lat);
      check("bp_second_latency", 32'(lat + 1), 32'd3);
      pop_compare("bp_second");
      handshake("bp_second");

      // Write to addr 20 during WAIT.
      drive_req(6'd7, 3'b111, {10'd30, 10'd20, 10'd10},
                {32'hC, (BYP ? 32'hDEAD : 32'hB), 32'hA}, 1'b1);
      step();
      req_valid = 1'b0;
      step();
      write_port(10'd20, 32'hDEAD);
      step();
      rf_wr0_en = '0;
      pop_compare("byp_wait");
      handshake("byp_wait");

      // READ-cycle write then WAIT-cycle write to the same address: WAIT wins.
      drive_req(6'd8, 3'b100, {10'd30, 10'd0, 10'd0},
                {(BYP ? 32'h2 : 32'hC), 32'h0, 32'h0}, 1'b1);
      step();
      req_valid = 1'b0;
      write_port(10'd30, 32'h1);
      step();
      write_port(10'd30, 32'h2);
      step();
      rf_wr0_en = '0;
      pop_compare("byp_prio");
      handshake("byp_prio");

      // READ-cycle write only: held in the pending register until capture.
      drive_req(6'd9, 3'b001, {10'd0, 10'd0, 10'd10},
                {32'h0, 32'h0, (BYP ? 32'h55 : 32'hA)}, 1'b1);
      step();
      req_valid = 1'b0;
      write_port(10'd10, 32'h55);
      step();
      rf_wr0_en = '0;
      step();
      pop_compare("byp_pend");
      write_port(10'd10, 32'h66);
      step();
      rf_wr0_en = '0;
      check("valid_write_not_forwarded", out_src0_data, BYP ? 32'h55 : 32'hA);
      handshake("byp_pend");

      // Reset during WAIT aborts the request.
      drive_req(6'd3, 3'b111, {10'd30, 10'd20, 10'd10}, '0, 1'b0);
      step();
      req_valid = 1'b0;
      step();
      rst = 1'b0;
      #1;
      check("rst_wait_out_valid", 32'(out_valid), 32'd0);
      check("rst_wait_req_ready", 32'(req_ready), 32'd1);
      check("rst_wait_out_tag",   32'(out_tag),   32'd0);
      check("rst_wait_rd0_addr",  32'(rf_rd0_addr), 32'd0);
      step();
      rst = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (out_valid) seen++;
      end
      check("rst_wait_no_output", 32'(seen), 32'd0);
      check("rst_wait_ready_after", 32'(req_ready), 32'd1);

      // Reset during VALID drops out_valid asynchronously.
      drive_req(6'd4, 3'b111, {10'd30, 10'd20, 10'd10}, '0, 1'b0);
      step();
      req_valid = 1'b0;
      wait_valid(lat);
      check("rst_valid_pre", 32'(out_valid), 32'd1);
      rst = 1'b0;
      #1;
      check("rst_valid_out_valid", 32'(out_valid), 32'd0);
      check("rst_valid_src2", out_src2_data, 32'd0);
      step();
      rst = 1'b1;
      step();

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
